// File: rtl/cam_frame_ctrl.sv
// Frame-level sequencer for the OV7670 capture path: camera bring-up, VSYNC
// watchdog and frame-boundary gating of the pixel-BRAM write enable.
module cam_frame_ctrl #(
    parameter int unsigned PWRUP_CYCLES  = 1_000_000,
    parameter int unsigned CFG_TIMEOUT   = 100_000_000,
    parameter int unsigned FRAME_TIMEOUT = 10_000_000,
    parameter int unsigned SETTLE_FRAMES = 2
) (
    input  logic        i_top_clk,
    input  logic        w_rst_btn_db,
    input  logic        i_mode_snap,
    input  logic        i_snap_req,
    input  logic        i_cam_done,
    input  logic        i_vsync_async,
    output logic        o_cam_start,
    output logic        o_wr_en,
    output logic [15:0] o_frame_cnt,
    output logic        o_busy,
    output logic        o_err,
    output logic [2:0]  o_state
);

    localparam int unsigned PW = $clog2(PWRUP_CYCLES) + 1;
    localparam int unsigned CW = $clog2(CFG_TIMEOUT) + 1;
    localparam int unsigned FW = $clog2(FRAME_TIMEOUT) + 1;

    localparam logic [PW-1:0] PWR_LAST    = PW'(PWRUP_CYCLES);
    localparam logic [CW-1:0] CFG_LAST    = CW'(CFG_TIMEOUT - 1);
    localparam logic [FW-1:0] WD_LAST     = FW'(FRAME_TIMEOUT - 1);
    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

    localparam logic [2:0] ST_PWRUP  = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_CFG    = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    localparam logic [1:0] SUB_FROZEN  = 2'd0;
    localparam logic [1:0] SUB_ARMED   = 2'd1;
    localparam logic [1:0] SUB_CAPTURE = 2'd2;

    logic          r_vs_meta;
    logic          r_vs_sync;
    logic          r_vs_prev;
    logic          w_vs_rise;
    logic          w_wd_expire;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [1:0]    r_sub;
    logic [PW-1:0] r_pwr_cnt;
    logic [CW-1:0] r_cfg_cnt;
    logic [FW-1:0] r_wd_cnt;
    logic [3:0]    r_settle_cnt;

    logic          r_cam_start;
    logic          r_wr_en;
    logic [15:0]   r_frame_cnt;
    logic          r_busy;
    logic          r_err;

    always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
        if (!w_rst_btn_db) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_meta <= i_vsync_async;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_vs_rise = r_vs_sync & ~r_vs_prev;
    // A frame edge landing on the expiry cycle rescues the watchdog.
    assign w_wd_expire = (r_wd_cnt == WD_LAST) & ~w_vs_rise;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PWRUP:  if (r_pwr_cnt == PWR_LAST) w_state_nxt = ST_START;
            ST_START:  w_state_nxt = ST_CFG;
            ST_CFG: begin
                if (i_cam_done)                w_state_nxt = ST_SETTLE;
                else if (r_cfg_cnt == CFG_LAST) w_state_nxt = ST_ERR;
            end
            ST_SETTLE: begin
                if (w_wd_expire)                                  w_state_nxt = ST_ERR;
                else if (w_vs_rise && r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_RUN;
            end
            ST_RUN:    if (w_wd_expire) w_state_nxt = ST_ERR;
            default:   w_state_nxt = ST_PWRUP;
        endcase
    end

    always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
        if (!w_rst_btn_db) begin
            r_pwr_cnt    <= '0;
            r_cfg_cnt    <= '0;
            r_wd_cnt     <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_pwr_cnt <= (r_state == ST_PWRUP) ? r_pwr_cnt + 1'b1 : '0;
            r_cfg_cnt <= (r_state == ST_CFG)   ? r_cfg_cnt + 1'b1 : '0;
            if ((r_state == ST_SETTLE || r_state == ST_RUN) && !w_vs_rise)
                r_wd_cnt <= r_wd_cnt + 1'b1;
            else
                r_wd_cnt <= '0;
            if (r_state != ST_SETTLE)
                r_settle_cnt <= '0;
            else if (w_vs_rise)
                r_settle_cnt <= r_settle_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
        if (!w_rst_btn_db) begin
            r_state     <= ST_PWRUP;
            r_sub       <= SUB_FROZEN;
            r_cam_start <= 1'b0;
            r_wr_en     <= 1'b0;
            r_frame_cnt <= '0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cam_start <= (w_state_nxt == ST_START);
            r_busy      <= (w_state_nxt != ST_RUN);
            if (w_state_nxt == ST_ERR) begin
                r_err   <= 1'b1;
                r_wr_en <= 1'b0;
                r_sub   <= SUB_FROZEN;
            end else if (r_state != ST_RUN) begin
                r_sub   <= SUB_FROZEN;
                r_wr_en <= (w_state_nxt == ST_RUN) && !i_mode_snap;
            end else if (w_vs_rise) begin
                // A frame counts as captured when write enable covered it.
                if (r_wr_en)
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                if (!i_mode_snap) begin
                    r_wr_en <= 1'b1;
                    r_sub   <= SUB_FROZEN;
                end else begin
                    case (r_sub)
                        SUB_ARMED: begin
                            r_wr_en <= 1'b1;
                            r_sub   <= SUB_CAPTURE;
                        end
                        SUB_CAPTURE: begin
                            r_wr_en <= 1'b0;
                            r_sub   <= SUB_FROZEN;
                        end
                        default: begin
                            r_wr_en <= 1'b0;
                            r_sub   <= i_snap_req ? SUB_ARMED : SUB_FROZEN;
                        end
                    endcase
                end
            end else if (i_mode_snap && i_snap_req && r_sub == SUB_FROZEN) begin
                r_sub <= SUB_ARMED;
            end
        end
    end

    assign o_cam_start = r_cam_start;
    assign o_wr_en     = r_wr_en;
    assign o_frame_cnt = r_frame_cnt;
    assign o_busy      = r_busy;
    assign o_err       = r_err;
    assign o_state     = r_state;

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Directed bench for cam_frame_ctrl: bring-up, continuous/snapshot capture,
// configuration and frame timeouts, and asynchronous reset mid-capture.
module tb_cam_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_snap;
    logic        snap_req;
    logic        cam_done;
    logic        vsync;
    logic        cam_start;
    logic        wr_en;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        err;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vs_en = 0;
    int phase = 59;
    logic wr_prev = 1'b0;
    int wr_rise_cyc = 0;
    int wr_fall_cyc = 0;
    int at = 0;
    int cfg_entry = 0;

    cam_frame_ctrl #(
        .PWRUP_CYCLES (10),
        .CFG_TIMEOUT  (50),
        .FRAME_TIMEOUT(100),
        .SETTLE_FRAMES(2)
    ) dut (
        .i_top_clk    (clk),
        .w_rst_btn_db (rst_n),
        .i_mode_snap  (mode_snap),
        .i_snap_req   (snap_req),
        .i_cam_done   (cam_done),
        .i_vsync_async(vsync),
        .o_cam_start  (cam_start),
        .o_wr_en      (wr_en),
        .o_frame_cnt  (frame_cnt),
        .o_busy       (busy),
        .o_err        (err),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample 1 time unit after the edge, then drive VSYNC (60-cycle period, 10 high).
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (vs_en != 0) begin
            phase = (phase == 59) ? 0 : phase + 1;
            vsync = (phase < 10);
        end
        if (wr_en !== wr_prev) begin
            if (wr_en) wr_rise_cyc = cyc;
            else       wr_fall_cyc = cyc;
            wr_prev = wr_en;
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int when);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        when = (state === s) ? cyc : -1;
    endtask

    task automatic wait_start(input int budget, output int when);
        int n = 0;
        while (cam_start !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        when = (cam_start === 1'b1) ? cyc : -1;
    endtask

    initial begin
        rst_n = 1'b0; mode_snap = 1'b0; snap_req = 1'b0; cam_done = 1'b0; vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_cam_start", cam_start, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 1);
        chk("rst_err", err, 0);

        // Bring-up: start pulse 11 cycles after release, done raised 5 cycles later.
        rst_n = 1'b1;
        cyc = 0;
        wait_start(30, at);
        chk("start_cycle", at, 11);
        chk("start_state", state, 1);
        tick();
        chk("start_pulse_width", cam_start, 0);
        chk("cfg_state", state, 2);
        run_to(16);
        cam_done = 1'b1;
        tick();
        chk("settle_state", state, 3);
        vs_en = 1; phase = 59;
        wait_state(3'd4, 200, at);
        chk("run_on_2nd_rise", at, 81);
        chk("run_busy", busy, 0);
        chk("run_wr_en", wr_en, 1);
        chk("run_cnt_zero", frame_cnt, 0);

        // Continuous: rises at 141,201,261,321,381.
        run_to(381);
        chk("cont_cnt5", frame_cnt, 5);
        chk("cont_no_drop", wr_fall_cyc, 0);

        run_to(390);
        force dut.r_frame_cnt = 16'hFFFF;
        tick();
        release dut.r_frame_cnt;
        tick();
        chk("pre_wrap", frame_cnt, 16'hFFFF);
        run_to(441);
        chk("wrap_to_zero", frame_cnt, 0);

        // Snapshot: the rise at 501 finishes the last continuous frame.
        run_to(445);
        mode_snap = 1'b1;
        run_to(501);
        chk("c2s_wr_off", wr_en, 0);
        chk("c2s_cnt", frame_cnt, 1);
        run_to(530);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        run_to(590);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        run_to(621);
        chk("snap_wr_rise", wr_rise_cyc, 561);
        chk("snap_wr_fall", wr_fall_cyc, 621);
        chk("snap_cnt", frame_cnt, 2);
        run_to(700);
        chk("snap_no_queue_rise", wr_rise_cyc, 561);
        chk("snap_no_queue_cnt", frame_cnt, 2);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        run_to(800);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        chk("snap2_fall", wr_fall_cyc, 801);
        chk("snap2_cnt", frame_cnt, 3);
        run_to(870);
        chk("req_on_end_ignored", wr_rise_cyc, 741);
        chk("req_on_end_wr", wr_en, 0);

        mode_snap = 1'b0;
        run_to(921);
        chk("s2c_wr_on", wr_en, 1);
        chk("s2c_cnt", frame_cnt, 3);
        run_to(981);
        chk("s2c_cnt_next", frame_cnt, 4);

        // Watchdog: last rise 981 would expire at 1081; a rise exactly then rescues it.
        run_to(990);
        vs_en = 0;
        run_to(1078);
        vsync = 1'b1;
        run_to(1081);
        chk("edge_on_expiry_state", state, 4);
        chk("edge_on_expiry_cnt", frame_cnt, 5);
        run_to(1088);
        vsync = 1'b0;
        wait_state(3'd5, 200, at);
        chk("frame_timeout_cycle", at, 1181);
        chk("frame_timeout_wr", wr_en, 0);
        chk("frame_timeout_wr_fall", wr_fall_cyc, 1181);
        chk("frame_timeout_err", err, 1);
        chk("frame_timeout_cnt", frame_cnt, 5);
        tick();
        chk("err_to_pwrup", state, 0);

        // Retry with done still high: CFG lasts one cycle; no VSYNC, so SETTLE times out.
        wait_start(30, at);
        chk("retry_start", at, 1193);
        tick();
        chk("cfg_done_high", state, 2);
        tick();
        chk("cfg_done_high_next", state, 3);
        cam_done = 1'b0;
        wait_state(3'd5, 200, at);
        chk("settle_timeout", at, 1295);

        wait_start(30, at);
        chk("retry2_start", at, 1307);
        tick();
        cfg_entry = cyc;
        wait_state(3'd5, 100, at);
        chk("cfg_timeout_cycle", at, 1358);
        chk("cfg_dwell", at - cfg_entry, 50);
        wait_start(30, at);
        chk("cfg_retry_start", at, 1370);
        chk("err_sticky", err, 1);

        // Reset in the middle of a snapshot capture.
        cam_done = 1'b1; mode_snap = 1'b1; vs_en = 1; phase = 59;
        wait_state(3'd4, 300, at);
        chk("snap_entry_frozen", wr_en, 0);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        begin
            int n = 0;
            while (wr_en !== 1'b1 && n < 200) begin
                tick();
                n++;
            end
        end
        chk("capture_begins", wr_en, 1);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_wr_en", wr_en, 0);
        chk("async_rst_cnt", frame_cnt, 0);
        chk("async_rst_busy", busy, 1);
        chk("async_rst_err", err, 0);
        chk("async_rst_start", cam_start, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        wait_start(30, at);
        chk("rst_restart_start", at, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
